// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: job sequencer around a shift-add multiplier, with result FIFO and timeout flag.
module mul4_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 ck_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    output logic                 mul_start_o,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_b_o,
    input  logic                 mul_ready_i,
    input  logic [2*WIDTH-1:0]   mul_p_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_p_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAITLO = 2'd2, WAITHI = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d, wr_idx;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic               in_fire, wait_st, done, expire, pop;

    // A slot is reserved per accepted job, so capture never meets a full FIFO.
    assign in_ready_o  = state_q == IDLE && mul_ready_i && cnt_q < CW'(DEPTH);
    assign mul_start_o = state_q == LAUNCH;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign busy_o      = state_q != IDLE;
    assign err_o       = err_q;
    assign out_valid_o = cnt_q != '0;
    assign out_p_o     = out_valid_o ? mem_q[0] : '0;

    always_comb begin
        in_fire = in_valid_i && in_ready_o;
        wait_st = state_q == WAITLO || state_q == WAITHI;
        done    = state_q == WAITHI && mul_ready_i;
        expire  = wait_st && !done && tcnt_q == TW'(TIMEOUT - 1);
        pop     = out_valid_o && out_ready_i;
        wr_idx  = cnt_q - CW'(pop);
        cnt_d   = cnt_q + CW'(done) - CW'(pop);
        tcnt_d  = state_q == LAUNCH ? '0 : wait_st ? tcnt_q + 1'b1 : tcnt_q;
        err_d   = err_q || expire;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_fire ? LAUNCH : IDLE;
            LAUNCH:  state_d = WAITLO;
            WAITLO:  state_d = expire ? IDLE : !mul_ready_i ? WAITHI : WAITLO;
            default: state_d = (done || expire) ? IDLE : WAITHI;
        endcase
    end

    // Head lives in mem_q[0]; a pop shifts down, a push lands behind the surviving entries.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (in_fire) begin
                a_q <= in_a_i;
                b_q <= in_b_i;
            end
            for (int i = 0; i < DEPTH; i++)
                if (done && CW'(i) == wr_idx) mem_q[i] <= mul_p_i;
                else if (pop) mem_q[i] <= mem_q[i == DEPTH - 1 ? i : i + 1];
        end
    end
endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// tb_mul4_seq_ctrl: directed checks of mul4_seq_ctrl against a behavioural 4x4 multiplier model.
module tb_mul4_seq_ctrl;
    logic       ck_i = 1'b0, rst_i = 1'b1, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [3:0] in_a_i = '0, in_b_i = '0;
    logic       in_ready_o, mul_start_o, mul_ready_i, out_valid_o, busy_o, err_o;
    logic [3:0] mul_a_o, mul_b_o;
    logic [7:0] mul_p_i, out_p_o;

    int checks = 0, passed = 0;

    // Multiplier model: READY low for 5 cycles after START, product latched at START.
    logic       stuck = 1'b0;
    int         mcnt = 0;
    logic [7:0] prod = '0;
    assign mul_ready_i = mcnt == 0;
    assign mul_p_i     = prod;

    always @(posedge ck_i) begin
        if (mul_start_o && !stuck) begin
            mcnt <= 5;
            prod <= {4'b0, mul_a_o} * {4'b0, mul_b_o};
        end else if (mcnt != 0) mcnt <= mcnt - 1;
    end

    always #5 ck_i = ~ck_i;

    mul4_seq_ctrl dut (
        .ck_i(ck_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .mul_start_o(mul_start_o), .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o), .mul_ready_i(mul_ready_i), .mul_p_i(mul_p_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_p_o(out_p_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[3];

    task automatic tick();
        @(posedge ck_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    // Returns in the cycle after the handshake edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        in_a_i = a;
        in_b_i = b;
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 30) begin
            tick();
            n++;
        end
        chk("send_accept", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 30) begin
            tick();
            n++;
        end
        chk("wait_idle", busy_o, 0);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid_o && n < 30) begin
            tick();
            n++;
        end
        chk("wait_out", out_valid_o, 1);
    endtask

    initial begin
        vecs[0] = '{4'd15, 4'd15, 8'd225};
        vecs[1] = '{4'd0, 4'd5, 8'd0};
        vecs[2] = '{4'd1, 4'd1, 8'd1};

        // Reset state and nominal single-job timing
        repeat (2) tick();
        rst_i = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_p", out_p_o, 0);
        chk("rst_start", mul_start_o, 0);
        chk("rst_mul_a", mul_a_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        in_a_i = 4'd7;
        in_b_i = 4'd9;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        chk("t1_start", mul_start_o, 1);
        chk("t1_busy", busy_o, 1);
        chk("t1_mul_a", mul_a_o, 7);
        chk("t1_mul_b", mul_b_o, 9);
        chk("t1_in_ready_busy", in_ready_o, 0);
        tick();
        chk("t1_start_drop", mul_start_o, 0);
        repeat (5) tick();
        chk("t1_valid_n7", out_valid_o, 0);
        tick();
        chk("t1_valid_n8", out_valid_o, 1);
        chk("t1_out_p", out_p_o, 63);
        chk("t1_idle_n8", busy_o, 0);
        chk("t1_ready_n8", in_ready_o, 1);
        out_ready_i = 1'b1;
        tick();
        chk("t1_popped", out_valid_o, 0);

        // Back-to-back jobs with the consumer always ready
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].a, vecs[i].b);
            chk("t2_in_ready_busy", in_ready_o, 0);
            chk("t2_busy", busy_o, 1);
            wait_out();
            chk("t2_out_p", out_p_o, vecs[i].p);
        end
        tick();
        chk("t2_drained", out_valid_o, 0);
        out_ready_i = 1'b0;

        // Stalled consumer fills the FIFO and blocks the third job
        send(4'd15, 4'd15);
        wait_idle();
        send(4'd2, 4'd3);
        wait_idle();
        chk("t3_full_valid", out_valid_o, 1);
        chk("t3_full_head", out_p_o, 225);
        chk("t3_full_in_ready", in_ready_o, 0);
        in_a_i = 4'd3;
        in_b_i = 4'd3;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_blocked", busy_o, 0);
            chk("t3_head_hold", out_p_o, 225);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t3_head_after_pop", out_p_o, 6);
        chk("t3_in_ready_after_pop", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("t3_third_accepted", busy_o, 1);
        wait_idle();
        chk("t3_head_still", out_p_o, 6);
        out_ready_i = 1'b1;
        tick();
        chk("t3_third_result", out_p_o, 9);
        tick();
        chk("t3_empty", out_valid_o, 0);
        out_ready_i = 1'b0;

        // Multiplier never drops READY: abort after TIMEOUT waiting cycles
        stuck = 1'b1;
        send(4'd4, 4'd4);
        repeat (15) tick();
        chk("t4_err_before", err_o, 0);
        chk("t4_busy_before", busy_o, 1);
        tick();
        chk("t4_err", err_o, 1);
        chk("t4_idle", busy_o, 0);
        chk("t4_no_push", out_valid_o, 0);
        stuck = 1'b0;
        send(4'd2, 4'd5);
        wait_out();
        chk("t4_recover_p", out_p_o, 10);
        chk("t4_err_sticky", err_o, 1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Reset mid-job with one queued result
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t5_err_cleared", err_o, 0);
        send(4'd5, 4'd5);
        wait_idle();
        chk("t5_head", out_p_o, 25);
        send(4'd2, 4'd2);
        repeat (2) tick();
        chk("t5_busy_waithi", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t5_out_valid", out_valid_o, 0);
        chk("t5_out_p", out_p_o, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_start", mul_start_o, 0);
        in_a_i = 4'd3;
        in_b_i = 4'd3;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_in_ready_held", in_ready_o, 0);
            tick();
            chk("t5_not_accepted", busy_o, 0);
        end
        chk("t5_in_ready_back", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("t5_accepted", busy_o, 1);
        wait_out();
        chk("t5_result", out_p_o, 9);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Pop and capture in the same cycle with one entry queued
        send(4'd3, 4'd5);
        wait_idle();
        chk("t6_head_first", out_p_o, 15);
        send(4'd6, 4'd7);
        repeat (6) tick();
        chk("t6_busy_n7", busy_o, 1);
        chk("t6_head_n7", out_p_o, 15);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t6_valid", out_valid_o, 1);
        chk("t6_new_head", out_p_o, 42);
        tick();
        chk("t6_head_hold", out_p_o, 42);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t6_count_was_one", out_valid_o, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
